// File: rtl/memory_stage_controller.sv
// Memory-stage controller: launches a request/acknowledge access to a variable-latency
// data memory for the X/M instruction, stalls upstream while it is outstanding.
module memory_stage_controller #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_xm,
  input  logic        mem_write_xm,
  input  logic [3:0]  rt_xm,
  input  logic [15:0] alu_out_xm,
  input  logic [15:0] reg2_xm,
  input  logic        reg_write_mw,
  input  logic [3:0]  write_reg_mw,
  input  logic [15:0] wb_data_mw,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        stall,
  output logic [15:0] load_data,
  output logic        load_valid,
  output logic        mem_error,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Counter value seen in the last ACCESS cycle before a timeout.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state_reg, state_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic [15:0] mem_addr_reg, mem_addr_next;
  logic [15:0] mem_wdata_reg, mem_wdata_next;
  logic [15:0] load_data_reg, load_data_next;
  logic        load_valid_reg, load_valid_next;
  logic        mem_error_reg, mem_error_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;

  logic        acc;
  logic        fwd;
  logic [15:0] store_data;

  assign acc        = mem_read_xm | mem_write_xm;
  assign fwd        = mem_write_xm & reg_write_mw & (write_reg_mw == rt_xm) & (write_reg_mw != 4'd0);
  assign store_data = fwd ? wb_data_mw : reg2_xm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= 16'h0000;
      mem_wdata_reg  <= 16'h0000;
      load_data_reg  <= 16'h0000;
      load_valid_reg <= 1'b0;
      mem_error_reg  <= 1'b0;
      wait_cnt_reg   <= 8'd0;
    end else begin
      state_reg      <= state_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      load_data_reg  <= load_data_next;
      load_valid_reg <= load_valid_next;
      mem_error_reg  <= mem_error_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    load_data_next  = load_data_reg;
    load_valid_next = 1'b0;
    mem_error_next  = mem_error_reg;
    wait_cnt_next   = wait_cnt_reg;
    stall           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (acc) begin
          stall          = 1'b1;
          mem_addr_next  = alu_out_xm;
          mem_wdata_next = store_data;
          mem_we_next    = mem_write_xm;
          mem_req_next   = 1'b1;
          wait_cnt_next  = 8'd0;
          state_next     = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        // An ack arriving on the timeout cycle takes priority over the timeout.
        if (mem_ack) begin
          mem_req_next    = 1'b0;
          load_valid_next = 1'b1;
          if (!mem_we_reg) load_data_next = mem_rdata;
          state_next      = DONE;
        end else if (wait_cnt_reg == LAST_WAIT) begin
          mem_req_next    = 1'b0;
          mem_error_next  = 1'b1;
          load_valid_next = 1'b1;
          if (!mem_we_reg) load_data_next = 16'h0000;
          state_next      = DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign load_data  = load_data_reg;
  assign load_valid = load_valid_reg;
  assign mem_error  = mem_error_reg;
  assign busy       = (state_reg != IDLE);

endmodule
